// File: rtl/pipe_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard control slice.
//   REG_AW     : register address width
//   FWD_*      : operand mux select codes (11 is never produced)
//   stage_t    : per-stage shadow of the fields hazard logic needs
//   STAGE_BUBBLE : shadow value of an inserted bubble
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{dst: '0, regwrite: 1'b0, memread: 1'b0};

endpackage

// File: rtl/fwd_sel_calc.sv
// Combinational forwarding select for one EX operand.
//   src, uses_src        : source register of the ID instruction and its use flag
//   ex_dst, ex_regwrite  : EX shadow (result will sit in EX/MEM next cycle)
//   mem_dst, mem_regwrite: MEM shadow (result will sit in MEM/WB next cycle)
//   sel                  : FWD_EXMEM over FWD_WB over FWD_RF; r0 never forwarded
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              uses_src,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_regwrite,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_regwrite && (ex_dst != '0) && (ex_dst == src) && uses_src) begin
      sel = FWD_EXMEM;
    end else if (mem_regwrite && (mem_dst != '0) && (mem_dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding control and load-use hazard detection.
// Sits between the ID decoder and the ID/EX register, shadowing dst/regwrite/
// memread for EX, MEM and WB.
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : ID-stage instruction fields
//   flush               : squash the ID instruction (branch taken)
//   hold                : freeze all state (memory wait)
//   stall               : combinational load-use stall request
//   fwd_a_sel/fwd_b_sel : registered EX operand mux selects
//   ex_dst/mem_dst/wb_dst : shadow destination registers
//   stall_count         : saturating count of stall cycles
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = pipe_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic [CNT_W-1:0]  stall_count
);

  import pipe_pkg::*;

  stage_t            ex_q, ex_d;
  stage_t            mem_q, mem_d;
  stage_t            wb_q, wb_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [1:0]        sel_a, sel_b;
  logic              ex_hit;
  logic              unused_wb_flags;

  // WB flags are shadowed for completeness; nothing downstream reads them.
  assign unused_wb_flags = ^{wb_q.regwrite, wb_q.memread};

  fwd_sel_calc u_sel_a (
    .src          (id_rs),
    .uses_src     (id_uses_rs),
    .ex_dst       (ex_q.dst),
    .ex_regwrite  (ex_q.regwrite),
    .mem_dst      (mem_q.dst),
    .mem_regwrite (mem_q.regwrite),
    .sel          (sel_a)
  );

  fwd_sel_calc u_sel_b (
    .src          (id_rt),
    .uses_src     (id_uses_rt),
    .ex_dst       (ex_q.dst),
    .ex_regwrite  (ex_q.regwrite),
    .mem_dst      (mem_q.dst),
    .mem_regwrite (mem_q.regwrite),
    .sel          (sel_b)
  );

  // Load in EX whose result is needed by the ID instruction; a flushed ID
  // instruction never needs to wait.
  always_comb begin
    ex_hit = (id_uses_rs && (id_rs == ex_q.dst)) ||
             (id_uses_rt && (id_rt == ex_q.dst));
    stall  = ex_q.memread && ex_q.regwrite && (ex_q.dst != '0) &&
             id_valid && ex_hit && !flush;
  end

  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    fwd_a_d       = fwd_a_q;
    fwd_b_d       = fwd_b_q;
    stall_count_d = stall_count_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_valid && !flush && !stall) begin
        ex_d.dst      = id_dst;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        fwd_a_d       = sel_a;
        fwd_b_d       = sel_b;
      end else begin
        ex_d    = STAGE_BUBBLE;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end
      if (stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= STAGE_BUBBLE;
      mem_q         <= STAGE_BUBBLE;
      wb_q          <= STAGE_BUBBLE;
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign ex_dst      = ex_q.dst;
  assign mem_dst     = mem_q.dst;
  assign wb_dst      = wb_q.dst;
  assign stall_count = stall_count_q;

endmodule
